move_ctrl_unit: RTL and testbench

MOVE_CTRL_UNIT -- requirements
Module: move_ctrl_unit

---
 rtl/move_ctrl_unit.sv | 153 +++++++++++++++
 tb/tb_move_ctrl_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/move_ctrl_unit.sv
// Control sequencer for the move-from/move-to HI/LO instructions.
// It fetches through PC/MAR/MDR, waits on memory with a timeout, then executes MFHI, MFLO, MTHI or MTLO.
module move_ctrl_unit #(
    parameter int                     OPCODE_W = 5,
    parameter logic [OPCODE_W-1:0]    OPC_MFHI = 5'b11001,
    parameter logic [OPCODE_W-1:0]    OPC_MFLO = 5'b11010,
    parameter logic [OPCODE_W-1:0]    OPC_MTHI = 5'b10111,
    parameter logic [OPCODE_W-1:0]    OPC_MTLO = 5'b11000,
    parameter int                     MAX_WAIT = 15,
    parameter int                     CNT_W    = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Run,
    input  logic [OPCODE_W-1:0] IR_op,
    input  logic                Mem_ready,
    output logic                PCout,
    output logic                IncPC,
    output logic                MARin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Gra,
    output logic                Rin,
    output logic                Rout,
    output logic                HIout,
    output logic                LOout,
    output logic                HIin,
    output logic                LOin,
    output logic                Done,
    output logic                Illegal,
    output logic                Timeout,
    output logic [2:0]          State,
    output logic [CNT_W-1:0]    Instr_count
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T1W  = 3'd3,
        S_T2   = 3'd4,
        S_T3   = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_next;
    logic [CNT_W-1:0]    r_instr_cnt;
    logic                r_illegal;
    logic                r_timeout;
    logic                w_retire;
    logic                w_set_illegal;
    logic                w_set_timeout;

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        w_next        = r_state;
        w_wait_next   = '0;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        PCout   = 1'b0; IncPC  = 1'b0; MARin = 1'b0; Zin  = 1'b0;
        Zlowout = 1'b0; PCin   = 1'b0; Read  = 1'b0; MDRin = 1'b0;
        MDRout  = 1'b0; IRin   = 1'b0; Gra   = 1'b0; Rin  = 1'b0;
        Rout    = 1'b0; HIout  = 1'b0; LOout = 1'b0; HIin = 1'b0;
        LOin    = 1'b0;

        case (r_state)
            S_IDLE: if (Run) w_next = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                w_next = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                if (Mem_ready) begin
                    w_next = S_T2;
                end else begin
                    w_next      = S_T1W;
                    w_wait_next = WAIT_W'(1);
                end
            end
            // PCin stays low while waiting so the PC advances once per instruction.
            S_T1W: begin
                Read = 1'b1; MDRin = 1'b1;
                if (Mem_ready) begin
                    w_next = S_T2;
                end else if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
                    w_next        = S_ERR;
                    w_set_timeout = 1'b1;
                end else begin
                    w_wait_next = r_wait_cnt + WAIT_W'(1);
                end
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                w_next = S_T3;
            end
            S_T3: begin
                w_retire = 1'b1;
                if (IR_op == OPC_MFHI) begin
                    HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (IR_op == OPC_MFLO) begin
                    LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (IR_op == OPC_MTHI) begin
                    Gra = 1'b1; Rout = 1'b1; HIin = 1'b1;
                end else if (IR_op == OPC_MTLO) begin
                    Gra = 1'b1; Rout = 1'b1; LOin = 1'b1;
                end else begin
                    w_retire      = 1'b0;
                    w_set_illegal = 1'b1;
                end
                if (w_set_illegal) w_next = S_ERR;
                else               w_next = Run ? S_T0 : S_IDLE;
            end
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_instr_cnt <= '0;
            r_illegal   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_next;
            if (w_retire)      r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            if (w_set_illegal) r_illegal   <= 1'b1;
            if (w_set_timeout) r_timeout   <= 1'b1;
        end
    end

    assign Done        = w_retire;
    assign Illegal     = r_illegal;
    assign Timeout     = r_timeout;
    assign State       = r_state;
    assign Instr_count = r_instr_cnt;

endmodule

// File: tb/tb_move_ctrl_unit.sv
// Randomized bench for move_ctrl_unit: each instruction is expanded into its expected state trace
// from opcode, wait-state count and Run choice, and every cycle is compared against that trace.
module tb_move_ctrl_unit;

    localparam int OPCODE_W = 5;
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 2;
    localparam logic [4:0] MFHI = 5'b11001;
    localparam logic [4:0] MFLO = 5'b11010;
    localparam logic [4:0] MTHI = 5'b10111;
    localparam logic [4:0] MTLO = 5'b11000;
    localparam int ST_IDLE = 0, ST_T0 = 1, ST_T1 = 2, ST_T1W = 3, ST_T2 = 4, ST_T3 = 5, ST_ERR = 6;

    logic Clock = 1'b0;
    logic Reset, Run, Mem_ready;
    logic [OPCODE_W-1:0] IR_op;
    logic PCout, IncPC, MARin, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin;
    logic Gra, Rin, Rout, HIout, LOout, HIin, LOin;
    logic Done, Illegal, Timeout;
    logic [2:0] State;
    logic [CNT_W-1:0] Instr_count;

    move_ctrl_unit #(.OPCODE_W(OPCODE_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .IR_op(IR_op), .Mem_ready(Mem_ready),
        .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin), .Zlowout(Zlowout),
        .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Gra(Gra), .Rin(Rin), .Rout(Rout), .HIout(HIout), .LOout(LOout),
        .HIin(HIin), .LOin(LOin), .Done(Done), .Illegal(Illegal), .Timeout(Timeout),
        .State(State), .Instr_count(Instr_count)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic pc_out, inc_pc, mar_in, z_in, zlow_out, pc_in, read, mdr_in;
        logic mdr_out, ir_in, gra, r_in, r_out, hi_out, lo_out, hi_in, lo_in;
    } ctrl_t;

    ctrl_t act;
    assign act = {PCout, IncPC, MARin, Zin, Zlowout, PCin, Read, MDRin,
                  MDRout, IRin, Gra, Rin, Rout, HIout, LOout, HIin, LOin};

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int m_count;
    bit m_illegal, m_timeout;
    int cur_state;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [4:0] op);
        return (op == MFHI) || (op == MFLO) || (op == MTHI) || (op == MTLO);
    endfunction

    function automatic ctrl_t exp_ctrl(input int st, input logic [4:0] op);
        ctrl_t c = '0;
        case (st)
            ST_T0:  begin c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; c.z_in = 1; end
            ST_T1:  begin c.zlow_out = 1; c.pc_in = 1; c.read = 1; c.mdr_in = 1; end
            ST_T1W: begin c.read = 1; c.mdr_in = 1; end
            ST_T2:  begin c.mdr_out = 1; c.ir_in = 1; end
            ST_T3: begin
                if (op == MFHI) begin c.hi_out = 1; c.gra = 1; c.r_in = 1; end
                if (op == MFLO) begin c.lo_out = 1; c.gra = 1; c.r_in = 1; end
                if (op == MTHI) begin c.gra = 1; c.r_out = 1; c.hi_in = 1; end
                if (op == MTLO) begin c.gra = 1; c.r_out = 1; c.lo_in = 1; end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // One clock: drive inputs, compare every output, then advance past the next edge.
    task automatic cycle(input int st, input bit run, input bit mr, input logic [4:0] op, input bit rst);
        Run = run; Mem_ready = mr; IR_op = op; Reset = rst;
        #1;
        check("state",   32'(State),       32'(st));
        check("ctrl",    32'(act),         32'(exp_ctrl(st, op)));
        check("done",    32'(Done),        32'(st == ST_T3 && is_legal(op)));
        check("illegal", 32'(Illegal),     32'(m_illegal));
        check("timeout", 32'(Timeout),     32'(m_timeout));
        check("count",   32'(Instr_count), 32'(m_count % (1 << CNT_W)));
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    function automatic void model_reset();
        m_count = 0; m_illegal = 0; m_timeout = 0; cur_state = ST_IDLE;
    endfunction

    task automatic do_reset();
        cycle(cur_state, 1'($urandom), 1'($urandom), 5'($urandom), 1'b1);
        model_reset();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(ST_IDLE, 1'b0, 1'($urandom), 5'($urandom), 1'b0);
    endtask

    task automatic err_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(ST_ERR, 1'($urandom), 1'($urandom), 5'($urandom), 1'b0);
    endtask

    // w = number of memory cycles with Mem_ready low; w > MAX_WAIT means the data never arrives.
    task automatic run_instr(input logic [4:0] op, input int w, input bit run_after, input int rst_at);
        int trace[$];
        int mem_pos = 0;
        int n_wait;
        if (cur_state == ST_IDLE) trace.push_back(ST_IDLE);
        trace.push_back(ST_T0);
        trace.push_back(ST_T1);
        n_wait = (w > MAX_WAIT) ? MAX_WAIT : w;
        for (int k = 0; k < n_wait; k++) trace.push_back(ST_T1W);
        if (w > MAX_WAIT) trace.push_back(ST_ERR);
        else begin
            trace.push_back(ST_T2);
            trace.push_back(ST_T3);
        end
        for (int i = 0; i < trace.size(); i++) begin
            int st = trace[i];
            bit run = 1'($urandom);
            bit mr  = 1'($urandom);
            logic [4:0] o = 5'($urandom);
            bit rst = (i == rst_at);
            if (st == ST_IDLE) run = 1'b1;
            if (st == ST_T3) begin run = run_after; o = op; end
            if (st == ST_T1 || st == ST_T1W) begin
                mr = (mem_pos >= w);
                mem_pos++;
            end
            cycle(st, run, mr, o, rst);
            if (rst) begin
                model_reset();
                return;
            end
            if (st == ST_T1W && i + 1 < trace.size() && trace[i+1] == ST_ERR) m_timeout = 1;
            if (st == ST_ERR) cur_state = ST_ERR;
            if (st == ST_T3) begin
                if (is_legal(op)) begin
                    m_count++;
                    cur_state = run_after ? ST_T0 : ST_IDLE;
                end else begin
                    m_illegal = 1;
                    cur_state = ST_ERR;
                end
            end
        end
    endtask

    initial begin
        logic [4:0] ops [4];
        ops[0] = MFHI; ops[1] = MFLO; ops[2] = MTHI; ops[3] = MTLO;
        Reset = 1'b1; Run = 1'b0; Mem_ready = 1'b0; IR_op = '0;
        repeat (2) @(posedge Clock);
        #1;
        model_reset();
        idle_cycles(3);

        run_instr(MFLO, 0, 1'b0, -1);
        run_instr(MTHI, 3, 1'b0, -1);
        run_instr(MTLO, MAX_WAIT + 1, 1'b1, -1);
        err_cycles(4);
        do_reset();
        idle_cycles(1);
        run_instr(5'b00000, 0, 1'b0, -1);
        err_cycles(2);
        do_reset();
        for (int k = 0; k < 5; k++) run_instr((k % 2) ? MFLO : MFHI, 0, k < 4, -1);
        check("wrap", 32'(Instr_count), 32'd1);
        run_instr(MFHI, MAX_WAIT, 1'b0, -1);
        run_instr(MFLO, 0, 1'b0, 3);
        idle_cycles(1);

        for (int n = 0; n < 120; n++) begin
            logic [4:0] op = ops[$urandom_range(0, 3)];
            int w = $urandom_range(0, 4);
            int rst_at = -1;
            if ($urandom_range(0, 7) == 0) op = 5'($urandom);
            if ($urandom_range(0, 9) == 0) w = $urandom_range(MAX_WAIT - 2, MAX_WAIT + 2);
            if ($urandom_range(0, 14) == 0) rst_at = $urandom_range(0, 4);
            run_instr(op, w, 1'($urandom), rst_at);
            if (cur_state == ST_ERR) begin
                err_cycles(2);
                do_reset();
            end else if (cur_state == ST_IDLE && $urandom_range(0, 3) == 0) begin
                idle_cycles($urandom_range(1, 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
